// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the binary32 multiplier normalize/round stage.
// Widths are fixed to single precision.
package fp_mul_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned EXPS_W  = 10;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef logic signed [EXPS_W-1:0] exps_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid;
    } flags_t;

    typedef enum logic [2:0] {
        SEL_NORM,
        SEL_QNAN,
        SEL_INF,
        SEL_ZERO,
        SEL_OVF,
        SEL_UNF
    } sel_e;

endpackage

// File: rtl/fp_mul_norm_round_if.sv
// Operation/result handshake bundle for fp_mul_norm_round.
// master drives operations and out_ready; slave is the pipeline stage.
interface fp_mul_norm_round_if;
    import fp_mul_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXPS_W-1:0]   in_exp;
    logic [PROD_W-1:0]   in_prod;
    logic                in_zero;
    logic                in_inf;
    logic                in_nan;

    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic                out_overflow;
    logic                out_underflow;
    logic                out_inexact;
    logic                out_invalid;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_overflow, out_underflow,
        input  out_inexact, out_invalid
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_overflow, out_underflow,
        output out_inexact, out_invalid
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized 24-bit significand.
// A carry out of the significand renormalizes to 1.0 and bumps the exponent.
module fp_round_rne
    import fp_mul_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              sticky,
    input  exps_t             exp,
    output logic [MANT_W-1:0] mant_r,
    output exps_t             exp_r,
    output logic              inexact
);

    logic            round_up;
    logic [MANT_W:0] sum;

    always_comb begin
        round_up = guard & (sticky | mant[0]);
        sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        if (sum[MANT_W]) begin
            mant_r = sum[MANT_W:1];
            exp_r  = exp + exps_t'(1);
        end else begin
            mant_r = sum[MANT_W-1:0];
            exp_r  = exp;
        end
        inexact = guard | sticky;
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage normalize / round-and-pack pipeline for the binary32 multiplier.
// S1 registers the normalized significand; S2 rounds, applies specials and packs.
module fp_mul_norm_round
    import fp_mul_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    fp_mul_norm_round_if.slave  bus
);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    logic              s1_sign;
    logic              s1_zero;
    logic              s1_inf;
    logic              s1_nan;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_guard;
    logic              s1_sticky;
    exps_t             s1_exp;

    logic [MANT_W-1:0] n_mant;
    logic              n_guard;
    logic              n_sticky;
    exps_t             n_exp;

    logic [MANT_W-1:0] r_mant;
    exps_t             r_exp;
    logic              r_inexact;
    logic              unused_mant_msb;

    sel_e              sel;
    logic [31:0]       nxt_result;
    flags_t            nxt_flags;
    logic [31:0]       out_result_q;
    flags_t            out_flags_q;

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        if (bus.in_prod[47]) begin
            n_mant   = bus.in_prod[47:24];
            n_guard  = bus.in_prod[23];
            n_sticky = |bus.in_prod[22:0];
            n_exp    = exps_t'(bus.in_exp) + exps_t'(1);
        end else begin
            n_mant   = bus.in_prod[46:23];
            n_guard  = bus.in_prod[22];
            n_sticky = |bus.in_prod[21:0];
            n_exp    = exps_t'(bus.in_exp);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (s1_adv && bus.in_valid) begin
            s1_sign   <= bus.in_sign;
            s1_zero   <= bus.in_zero;
            s1_inf    <= bus.in_inf;
            s1_nan    <= bus.in_nan;
            s1_mant   <= n_mant;
            s1_guard  <= n_guard;
            s1_sticky <= n_sticky;
            s1_exp    <= n_exp;
        end
    end

    fp_round_rne u_round (
        .mant    (s1_mant),
        .guard   (s1_guard),
        .sticky  (s1_sticky),
        .exp     (s1_exp),
        .mant_r  (r_mant),
        .exp_r   (r_exp),
        .inexact (r_inexact)
    );

    // The hidden bit is implied in the packed format.
    assign unused_mant_msb = r_mant[MANT_W-1];

    // Overflow/underflow are judged on the post-rounding exponent.
    always_comb begin
        sel = SEL_NORM;
        if (s1_nan || (s1_inf && s1_zero)) begin
            sel = SEL_QNAN;
        end else if (s1_inf) begin
            sel = SEL_INF;
        end else if (s1_zero) begin
            sel = SEL_ZERO;
        end else if (r_exp >= exps_t'(EXP_MAX)) begin
            sel = SEL_OVF;
        end else if (r_exp <= exps_t'(0)) begin
            sel = SEL_UNF;
        end

        nxt_result        = {s1_sign, r_exp[7:0], r_mant[MANT_W-2:0]};
        nxt_flags         = '0;
        nxt_flags.inexact = r_inexact;
        case (sel)
            SEL_QNAN: begin
                nxt_result        = QNAN;
                nxt_flags         = '0;
                nxt_flags.invalid = s1_inf & s1_zero;
            end
            SEL_INF: begin
                nxt_result = {s1_sign, 8'hFF, 23'h0};
                nxt_flags  = '0;
            end
            SEL_ZERO: begin
                nxt_result = {s1_sign, 31'h0};
                nxt_flags  = '0;
            end
            SEL_OVF: begin
                nxt_result         = {s1_sign, 8'hFF, 23'h0};
                nxt_flags          = '0;
                nxt_flags.overflow = 1'b1;
                nxt_flags.inexact  = 1'b1;
            end
            SEL_UNF: begin
                nxt_result          = {s1_sign, 31'h0};
                nxt_flags           = '0;
                nxt_flags.underflow = 1'b1;
                nxt_flags.inexact   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid     <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result_q <= nxt_result;
                out_flags_q  <= nxt_flags;
            end
        end
    end

    assign bus.out_valid     = s2_valid;
    assign bus.out_result    = out_result_q;
    assign bus.out_overflow  = out_flags_q.overflow;
    assign bus.out_underflow = out_flags_q.underflow;
    assign bus.out_inexact   = out_flags_q.inexact;
    assign bus.out_invalid   = out_flags_q.invalid;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: directed cases, backpressure, reset flush and
// randomized operations against an arithmetic reference model.
module tb_fp_mul_norm_round;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ix;
        logic        iv;
    } exp_t;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [47:0] p;
        logic        z;
        logic        i;
        logic        n;
        exp_t        x;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mul_norm_round_if bus ();

    fp_mul_norm_round dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    op_t  pend[$];
    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t x);
        check({tag, "_result"}, bus.out_result, x.res);
        check({tag, "_flags"},
              32'({bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_invalid}),
              32'({x.ov, x.un, x.ix, x.iv}));
    endtask

    function automatic exp_t ex(logic [31:0] r, bit ov, bit un, bit ix, bit iv);
        exp_t x;
        x.res = r; x.ov = ov; x.un = un; x.ix = ix; x.iv = iv;
        return x;
    endfunction

    // Reference: integer division of the product into kept bits and remainder,
    // then round-half-to-even on the remainder against exactly one half ulp.
    function automatic exp_t mdl(bit s, int e, logic [47:0] p, bit z, bit i, bit n);
        exp_t            r;
        longint unsigned pv, m, rem, half;
        int              sh, ee;
        r = '0;
        if (n || (i && z)) begin
            r.res = 32'h7FC00000;
            r.iv  = i && z;
            return r;
        end
        if (i) begin r.res = {s, 8'hFF, 23'h0}; return r; end
        if (z) begin r.res = {s, 31'h0};        return r; end
        pv = 64'(p);
        if (pv >= (64'd1 << 47)) begin sh = 24; ee = e + 1; end
        else                     begin sh = 23; ee = e;     end
        m    = pv >> sh;
        rem  = pv % (64'd1 << sh);
        half = 64'd1 << (sh - 1);
        r.ix = (rem != 0);
        if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
        if (m == (64'd1 << 24)) begin m = 64'd1 << 23; ee = ee + 1; end
        if (ee >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.ov = 1'b1; r.ix = 1'b1;
        end else if (ee <= 0) begin
            r.res = {s, 31'h0}; r.un = 1'b1; r.ix = 1'b1;
        end else begin
            r.res = {s, 8'(ee), 23'(m)};
        end
        return r;
    endfunction

    function automatic op_t mk(bit s, int e, logic [47:0] p, bit z, bit i, bit n, exp_t x);
        op_t o;
        o.s = s; o.e = 10'(e); o.p = p; o.z = z; o.i = i; o.n = n; o.x = x;
        return o;
    endfunction

    // One cycle: drive at the falling edge, evaluate handshakes just after,
    // then let the rising edge happen.
    task automatic tick();
        exp_t x;
        if (pend.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_sign  = pend[0].s;
            bus.in_exp   = pend[0].e;
            bus.in_prod  = pend[0].p;
            bus.in_zero  = pend[0].z;
            bus.in_inf   = pend[0].i;
            bus.in_nan   = pend[0].n;
        end else begin
            bus.in_valid = 1'b0;
        end
        #2;
        if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                x = expq.pop_front();
                cmp_out("out", x);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            expq.push_back(pend[0].x);
            pend.delete(0);
            acc++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pend.size() > 0 || expq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(pend.size() + expq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_prod   = '0;
        bus.in_zero   = 1'b0;
        bus.in_inf    = 1'b0;
        bus.in_nan    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        cmp_out("rst", ex(32'h0, 0, 0, 0, 0));
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // 1.5 x 1.5 with explicit latency check
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 10'd127;
        bus.in_prod   = 48'h900000000000;
        bus.out_ready = 1'b1;
        #2;
        check("lat_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        check("lat_cyc1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_cyc2_valid", 32'(bus.out_valid), 32'd1);
        cmp_out("mul_1p5", ex(32'h40100000, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        check("lat_drained", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        // Directed rounding, boundary and special cases
        pend.push_back(mk(0, 127, 48'h7FFFFFC00000, 0, 0, 0, ex(32'h40000000, 0, 0, 1, 0)));
        pend.push_back(mk(0, 127, 48'h400000400000, 0, 0, 0, ex(32'h3F800000, 0, 0, 1, 0)));
        pend.push_back(mk(0, 127, 48'h400000400001, 0, 0, 0, ex(32'h3F800001, 0, 0, 1, 0)));
        pend.push_back(mk(0, 300, 48'h800000000000, 0, 0, 0, ex(32'h7F800000, 1, 0, 1, 0)));
        pend.push_back(mk(1, -10, 48'h800000000000, 0, 0, 0, ex(32'h80000000, 0, 1, 1, 0)));
        pend.push_back(mk(0, 127, 48'h800000000000, 1, 1, 0, ex(32'h7FC00000, 0, 0, 0, 1)));
        pend.push_back(mk(1, 127, 48'h800000000000, 0, 0, 1, ex(32'h7FC00000, 0, 0, 0, 0)));
        pend.push_back(mk(1, 127, 48'h800000000000, 1, 0, 0, ex(32'h80000000, 0, 0, 0, 0)));
        pend.push_back(mk(1, 127, 48'h800000000000, 0, 1, 0, ex(32'hFF800000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 254, 48'h7FFFFFC00000, 0, 0, 0, ex(32'h7F800000, 1, 0, 1, 0)));
        pend.push_back(mk(0, 254, 48'h400000000000, 0, 0, 0, ex(32'h7F000000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 254, 48'h800000000000, 0, 0, 0, ex(32'h7F800000, 1, 0, 1, 0)));
        pend.push_back(mk(0, 0,   48'h800000000000, 0, 0, 0, ex(32'h00800000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 1,   48'h400000000000, 0, 0, 0, ex(32'h00800000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 0,   48'h400000000000, 0, 0, 0, ex(32'h00000000, 0, 1, 1, 0)));
        bus.out_ready = 1'b1;
        drain("directed_drain", 200);

        // Backpressure: four queued operations, output stalled for four cycles
        bus.out_ready = 1'b0;
        acc = 0;
        pend.push_back(mk(0, 130, 48'h900000000000, 0, 0, 0, ex(32'h41900000, 0, 0, 0, 0)));
        pend.push_back(mk(1, 127, 48'h400000000000, 0, 0, 0, ex(32'hBF800000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 100, 48'hC00000000000, 0, 0, 0, ex(32'h32C00000, 0, 0, 0, 0)));
        pend.push_back(mk(1, 200, 48'h600000000000, 0, 0, 0, ex(32'hE4400000, 0, 0, 0, 0)));
        held = 32'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k >= 1) begin
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_result", bus.out_result, 32'h41900000);
            end
            if (k == 1) held = bus.out_result;
        end
        check("bp_stable", bus.out_result, held);
        check("bp_accepted", 32'(acc), 32'd2);
        bus.out_ready = 1'b1;
        drain("bp_drain", 100);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        pend.push_back(mk(0, 127, 48'h900000000000, 0, 0, 0, ex(32'h40100000, 0, 0, 0, 0)));
        pend.push_back(mk(0, 128, 48'h900000000000, 0, 0, 0, ex(32'h40900000, 0, 0, 0, 0)));
        tick();
        tick();
        check("rstmid_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        #2;
        check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        cmp_out("rstmid", ex(32'h0, 0, 0, 0, 0));
        check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("rstmid_no_ghost", 32'(bus.out_valid), 32'd0);

        // Randomized operations with random output backpressure
        for (int n = 0; n < 400; n++) begin
            bit          s, z, i, nn;
            int          e;
            logic [47:0] p;
            int          edges[9] = '{-127, -1, 0, 1, 2, 253, 254, 255, 383};
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) e = edges[$urandom_range(0, 8)];
            else                          e = int'($urandom_range(0, 510)) - 127;
            p = {16'($urandom), $urandom};
            if ($urandom_range(0, 1) == 1) p[47] = 1'b1;
            else begin p[47] = 1'b0; p[46] = 1'b1; end
            case ($urandom_range(0, 7))
                0: p[21:0] = '0;
                1: p[22:0] = '0;
                2: p[45:24] = '1;
                default: ;
            endcase
            z  = ($urandom_range(0, 15) == 0);
            i  = ($urandom_range(0, 15) == 0);
            nn = ($urandom_range(0, 15) == 0);
            pend.push_back(mk(s, e, p, z, i, nn, mdl(s, e, p, z, i, nn)));
        end
        for (int c = 0; c < 4000 && (pend.size() > 0 || expq.size() > 0); c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.out_ready = 1'b1;
        drain("rand_drain", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
